control_sequencer: RTL and testbench
====================================

// Module: control_sequencer
// PURPOSE
//  Step-sequenced control unit driving the CPU datapath's control inputs. These are the signals
//  the Phase-1 benches toggle by hand. Runs fetch (T0-T2) and execute (T3-T6) for register-class
//  ALU, mul/div, unary (neg/not), nop and halt. Decodes the IR word returned by the datapath.
//  Sits beside the CPU datapath; register selection uses Gra/Grb/Grc plus Rin/Rout, decoded in
//  the datapath.
// PARAMETERS
//  OPW        5   opcode width (IR[31:27])
//  WAIT_MAX   15  max T1 cycles waiting on mem_ready before fault
// PORTS
//  clock     in   1   single clock; state advances on posedge
//  clear_n   in   1   asynchronous, active-low reset
//  ir        in   32  IR contents from datapath (valid from T3 onward)
//  mem_ready in   1   memory read data valid on mDataIn this cycle
//  PCout,MARin,IncPC,memRead,MDRin,MDRout,IRin  out 1 each  fetch-path controls
//  Yin,Zin,Zlowout,Zhighout,HIin,LOin           out 1 each  ALU-path controls
//  Gra,Grb,Grc,Rin,Rout                         out 1 each  register-field select + strobes
//  alu_op    out  5   ALU operation (= IR opcode), valid in the Zin cycle, else 0
//  run       out  1   1 while sequencing; 0 after halt or fault
//  mem_fault out  1   sticky; set on T1 timeout
// BEHAVIOUR
//  - Reset (clear_n=0, async): state=T0, wait_cnt=0, mem_fault=0, run=1; all control outputs 0
//    while reset is held.
//  - Outputs are Moore, a pure decode of the registered state. Each is high for the whole cycle.
//  - T0: PCout, MARin, IncPC.
//  - T1: memRead, MDRin.
//    - Stay in T1 until mem_ready=1. wait_cnt counts T1 cycles with mem_ready=0.
//    - When wait_cnt reaches WAIT_MAX with mem_ready still 0: go to HALT, set mem_fault.
//    - mem_ready=1 in the same cycle as the limit: data wins, go to T2.
//  - T2: MDRout, IRin. Next state by ir[31:27], sampled in T3's first cycle:
//    - ALU3 {add 3, sub 4, shr 5, shra 6, shl 7, ror 8, rol 9, and 10, or 11}:
//      T3 Grb,Rout,Yin. T4 Grc,Rout,Zin,alu_op. T5 Zlowout,Gra,Rin. Then T0.
//    - MULDIV {div 15, mul 16}:
//      T3 Gra,Rout,Yin. T4 Grb,Rout,Zin,alu_op. T5 Zlowout,LOin. T6 Zhighout,HIin. Then T0.
//    - UNARY {neg 17, not 18}:
//      T3 Grb,Rout,Zin,alu_op. T4 Zlowout,Gra,Rin. Then T0.
//    - nop 26: T3 with no controls asserted, then T0.
//    - halt 27: HALT.
//    - Any other opcode: treated as nop, one T3 cycle with no controls.
//  - HALT: every control output 0, run=0. Only reset leaves HALT.
//  - Reset mid-instruction aborts immediately; no partial Rin/LOin/HIin pulse after clear_n falls.
//  - Cycle counts with mem_ready tied high: ALU3 6, MULDIV 7, UNARY 5, nop 4.
//  - Never more than one of {Gra,Grb,Grc} high; never Rin and Rout together.
// STRUCTURE
//  - Shared package cpu_defs: opcode localparams (OPW=5), state encoding T0..T6/HALT,
//    op-class enum {ALU3, MULDIV, UNARY, NOP, HALT}.
//  - Sub-module opcode_classifier (combinational, ir[31:27] -> op class) shared with later
//    load/store/branch work.
//  - Sequencer FSM and wait counter stay in this file.
// TESTING
//  1 Reset: hold clear_n=0 3 cycles -> all controls 0, run=1, mem_fault=0. Release -> PCout,
//    MARin, IncPC high on the next posedge-aligned cycle (T0).
//  2 NOT R6,R7: ir=0x9338_0000, mem_ready=1 -> T3 Grb,Rout,Zin, alu_op=18; T4 Zlowout,Gra,Rin;
//    T0 again at cycle 5.
//  3 ADD R2,R3,R4: ir=0x191A_0000 -> T3 Grb/Yin, T4 Grc/Zin with alu_op=3, T5 Gra/Rin.
//    6 cycles total.
//  4 MUL R3,R4: ir=0x81A0_0000 -> T5 Zlowout+LOin, T6 Zhighout+HIin. No Rin in any step.
//  5 mem_ready low 3 cycles -> memRead and MDRin high 4 cycles, then T2.
//    mem_ready never high -> mem_fault=1, run=0 after 15 T1 cycles.
//  6 halt ir=0xD800_0000 -> run=0, outputs frozen at 0 for 20 cycles.
//    clear_n pulsed low during a T4 (ADD) -> Zin drops asynchronously, restart at T0.

Source files
------------

// File: rtl/control_sequencer_pkg.sv
// Shared CPU control definitions: opcodes, sequencer step encoding,
// opcode classes and the bundle of datapath control strobes.
package cpu_defs;

    localparam int OPW = 5;

    localparam logic [OPW-1:0] OP_ADD  = 5'd3;
    localparam logic [OPW-1:0] OP_SUB  = 5'd4;
    localparam logic [OPW-1:0] OP_SHR  = 5'd5;
    localparam logic [OPW-1:0] OP_SHRA = 5'd6;
    localparam logic [OPW-1:0] OP_SHL  = 5'd7;
    localparam logic [OPW-1:0] OP_ROR  = 5'd8;
    localparam logic [OPW-1:0] OP_ROL  = 5'd9;
    localparam logic [OPW-1:0] OP_AND  = 5'd10;
    localparam logic [OPW-1:0] OP_OR   = 5'd11;
    localparam logic [OPW-1:0] OP_DIV  = 5'd15;
    localparam logic [OPW-1:0] OP_MUL  = 5'd16;
    localparam logic [OPW-1:0] OP_NEG  = 5'd17;
    localparam logic [OPW-1:0] OP_NOT  = 5'd18;
    localparam logic [OPW-1:0] OP_NOP  = 5'd26;
    localparam logic [OPW-1:0] OP_HALT = 5'd27;

    typedef enum logic [2:0] {
        ST_T0   = 3'd0,
        ST_T1   = 3'd1,
        ST_T2   = 3'd2,
        ST_T3   = 3'd3,
        ST_T4   = 3'd4,
        ST_T5   = 3'd5,
        ST_T6   = 3'd6,
        ST_HALT = 3'd7
    } state_e;

    typedef enum logic [2:0] {
        CLS_ALU3   = 3'd0,
        CLS_MULDIV = 3'd1,
        CLS_UNARY  = 3'd2,
        CLS_NOP    = 3'd3,
        CLS_HALT   = 3'd4
    } op_class_e;

    typedef struct packed {
        logic pc_out;
        logic mar_in;
        logic inc_pc;
        logic mem_read;
        logic mdr_in;
        logic mdr_out;
        logic ir_in;
        logic y_in;
        logic z_in;
        logic zlow_out;
        logic zhigh_out;
        logic hi_in;
        logic lo_in;
        logic gra;
        logic grb;
        logic grc;
        logic r_in;
        logic r_out;
    } ctrl_t;

endpackage

// File: rtl/control_sequencer_opcode_classifier.sv
// Maps an IR opcode field to the instruction class that selects the
// execute-step sequence. Unrecognised opcodes fall back to NOP.
module opcode_classifier
    import cpu_defs::*;
(
    input  logic [OPW-1:0] opcode_i,
    output op_class_e      op_class_o
);

    // Pure lookup from opcode to execute class
    always_comb begin
        op_class_o = CLS_NOP;
        case (opcode_i)
            OP_ADD, OP_SUB, OP_SHR, OP_SHRA, OP_SHL,
            OP_ROR, OP_ROL, OP_AND, OP_OR:   op_class_o = CLS_ALU3;
            OP_DIV, OP_MUL:                  op_class_o = CLS_MULDIV;
            OP_NEG, OP_NOT:                  op_class_o = CLS_UNARY;
            OP_NOP:                          op_class_o = CLS_NOP;
            OP_HALT:                         op_class_o = CLS_HALT;
            default:                         op_class_o = CLS_NOP;
        endcase
    end

endmodule

// File: rtl/control_sequencer.sv
// Step sequencer for the CPU datapath: fetch T0-T2, execute T3-T6.
// Controls are a Moore decode of the registered step; armed_q keeps every
// strobe low until the first clock edge after reset is released, so T0
// is always a full cycle and an asserted clear_n kills strobes at once.
module control_sequencer
    import cpu_defs::*;
#(
    parameter int OPW      = 5,
    parameter int WAIT_MAX = 15
) (
    input  logic           clock,
    input  logic           clear_n,
    input  logic [31:0]    ir,
    input  logic           mem_ready,
    output logic           PCout,
    output logic           MARin,
    output logic           IncPC,
    output logic           memRead,
    output logic           MDRin,
    output logic           MDRout,
    output logic           IRin,
    output logic           Yin,
    output logic           Zin,
    output logic           Zlowout,
    output logic           Zhighout,
    output logic           HIin,
    output logic           LOin,
    output logic           Gra,
    output logic           Grb,
    output logic           Grc,
    output logic           Rin,
    output logic           Rout,
    output logic [OPW-1:0] alu_op,
    output logic           run,
    output logic           mem_fault
);

    localparam int CW = $clog2(WAIT_MAX + 1);

    state_e          state_q;
    op_class_e       cls_q;
    op_class_e       cls_live;
    op_class_e       cls_use;
    logic            armed_q;
    logic            run_q;
    logic            mem_fault_q;
    logic [CW-1:0]   wait_cnt_q;
    ctrl_t           ctrl;
    logic            unused_ir_bits;

    assign unused_ir_bits = ^ir[31-OPW:0];

    opcode_classifier u_classifier (
        .opcode_i   (ir[31 -: OPW]),
        .op_class_o (cls_live)
    );

    // Step sequencing, T1 wait counter, sticky fault and run flag
    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            state_q     <= ST_T0;
            cls_q       <= CLS_NOP;
            armed_q     <= 1'b0;
            run_q       <= 1'b1;
            mem_fault_q <= 1'b0;
            wait_cnt_q  <= '0;
        end else if (!armed_q) begin
            armed_q <= 1'b1;
        end else begin
            case (state_q)
                ST_T0: state_q <= ST_T1;
                ST_T1: begin
                    if (mem_ready) begin
                        state_q    <= ST_T2;
                        wait_cnt_q <= '0;
                    end else if (wait_cnt_q == CW'(WAIT_MAX - 1)) begin
                        state_q     <= ST_HALT;
                        wait_cnt_q  <= CW'(WAIT_MAX);
                        mem_fault_q <= 1'b1;
                        run_q       <= 1'b0;
                    end else begin
                        wait_cnt_q <= wait_cnt_q + CW'(1);
                    end
                end
                ST_T2: state_q <= ST_T3;
                ST_T3: begin
                    cls_q <= cls_live;
                    case (cls_live)
                        CLS_ALU3, CLS_MULDIV, CLS_UNARY: state_q <= ST_T4;
                        CLS_HALT: begin
                            state_q <= ST_HALT;
                            run_q   <= 1'b0;
                        end
                        default: state_q <= ST_T0;
                    endcase
                end
                ST_T4: state_q <= (cls_q == CLS_UNARY) ? ST_T0 : ST_T5;
                ST_T5: state_q <= (cls_q == CLS_MULDIV) ? ST_T6 : ST_T0;
                ST_T6: state_q <= ST_T0;
                default: state_q <= ST_HALT;
            endcase
        end
    end

    // Moore decode of the current step into datapath strobes
    always_comb begin
        ctrl    = '0;
        cls_use = (state_q == ST_T3) ? cls_live : cls_q;
        if (armed_q) begin
            case (state_q)
                ST_T0: begin
                    ctrl.pc_out = 1'b1; ctrl.mar_in = 1'b1; ctrl.inc_pc = 1'b1;
                end
                ST_T1: begin
                    ctrl.mem_read = 1'b1; ctrl.mdr_in = 1'b1;
                end
                ST_T2: begin
                    ctrl.mdr_out = 1'b1; ctrl.ir_in = 1'b1;
                end
                ST_T3: begin
                    case (cls_use)
                        CLS_ALU3:   begin ctrl.grb = 1'b1; ctrl.r_out = 1'b1; ctrl.y_in = 1'b1; end
                        CLS_MULDIV: begin ctrl.gra = 1'b1; ctrl.r_out = 1'b1; ctrl.y_in = 1'b1; end
                        CLS_UNARY:  begin ctrl.grb = 1'b1; ctrl.r_out = 1'b1; ctrl.z_in = 1'b1; end
                        default: ;
                    endcase
                end
                ST_T4: begin
                    case (cls_use)
                        CLS_ALU3:   begin ctrl.grc = 1'b1; ctrl.r_out = 1'b1; ctrl.z_in = 1'b1; end
                        CLS_MULDIV: begin ctrl.grb = 1'b1; ctrl.r_out = 1'b1; ctrl.z_in = 1'b1; end
                        CLS_UNARY:  begin ctrl.zlow_out = 1'b1; ctrl.gra = 1'b1; ctrl.r_in = 1'b1; end
                        default: ;
                    endcase
                end
                ST_T5: begin
                    case (cls_use)
                        CLS_ALU3:   begin ctrl.zlow_out = 1'b1; ctrl.gra = 1'b1; ctrl.r_in = 1'b1; end
                        CLS_MULDIV: begin ctrl.zlow_out = 1'b1; ctrl.lo_in = 1'b1; end
                        default: ;
                    endcase
                end
                ST_T6: begin
                    ctrl.zhigh_out = 1'b1; ctrl.hi_in = 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign PCout     = ctrl.pc_out;
    assign MARin     = ctrl.mar_in;
    assign IncPC     = ctrl.inc_pc;
    assign memRead   = ctrl.mem_read;
    assign MDRin     = ctrl.mdr_in;
    assign MDRout    = ctrl.mdr_out;
    assign IRin      = ctrl.ir_in;
    assign Yin       = ctrl.y_in;
    assign Zin       = ctrl.z_in;
    assign Zlowout   = ctrl.zlow_out;
    assign Zhighout  = ctrl.zhigh_out;
    assign HIin      = ctrl.hi_in;
    assign LOin      = ctrl.lo_in;
    assign Gra       = ctrl.gra;
    assign Grb       = ctrl.grb;
    assign Grc       = ctrl.grc;
    assign Rin       = ctrl.r_in;
    assign Rout      = ctrl.r_out;
    assign alu_op    = ctrl.z_in ? ir[31 -: OPW] : '0;
    assign run       = run_q;
    assign mem_fault = mem_fault_q;

endmodule

// File: tb/tb_control_sequencer.sv
// Bench for control_sequencer: per-cycle expected control sets are built
// from the instruction-level step tables, then compared on every cycle.
module tb_control_sequencer;

    logic        clock = 1'b0;
    logic        clear_n;
    logic [31:0] ir;
    logic        mem_ready;
    logic PCout, MARin, IncPC, memRead, MDRin, MDRout, IRin;
    logic Yin, Zin, Zlowout, Zhighout, HIin, LOin;
    logic Gra, Grb, Grc, Rin, Rout;
    logic [4:0] alu_op;
    logic run, mem_fault;

    always #5 clock = ~clock;

    control_sequencer #(.OPW(5), .WAIT_MAX(15)) dut (
        .clock(clock), .clear_n(clear_n), .ir(ir), .mem_ready(mem_ready),
        .PCout(PCout), .MARin(MARin), .IncPC(IncPC), .memRead(memRead),
        .MDRin(MDRin), .MDRout(MDRout), .IRin(IRin),
        .Yin(Yin), .Zin(Zin), .Zlowout(Zlowout), .Zhighout(Zhighout),
        .HIin(HIin), .LOin(LOin),
        .Gra(Gra), .Grb(Grb), .Grc(Grc), .Rin(Rin), .Rout(Rout),
        .alu_op(alu_op), .run(run), .mem_fault(mem_fault)
    );

    localparam logic [17:0] C_PCOUT  = 18'd1 << 0;
    localparam logic [17:0] C_MARIN  = 18'd1 << 1;
    localparam logic [17:0] C_INCPC  = 18'd1 << 2;
    localparam logic [17:0] C_MEMRD  = 18'd1 << 3;
    localparam logic [17:0] C_MDRIN  = 18'd1 << 4;
    localparam logic [17:0] C_MDROUT = 18'd1 << 5;
    localparam logic [17:0] C_IRIN   = 18'd1 << 6;
    localparam logic [17:0] C_YIN    = 18'd1 << 7;
    localparam logic [17:0] C_ZIN    = 18'd1 << 8;
    localparam logic [17:0] C_ZLOW   = 18'd1 << 9;
    localparam logic [17:0] C_ZHIGH  = 18'd1 << 10;
    localparam logic [17:0] C_HIIN   = 18'd1 << 11;
    localparam logic [17:0] C_LOIN   = 18'd1 << 12;
    localparam logic [17:0] C_GRA    = 18'd1 << 13;
    localparam logic [17:0] C_GRB    = 18'd1 << 14;
    localparam logic [17:0] C_GRC    = 18'd1 << 15;
    localparam logic [17:0] C_RIN    = 18'd1 << 16;
    localparam logic [17:0] C_ROUT   = 18'd1 << 17;

    localparam logic [31:0] IR_NOT  = 32'h9338_0000;
    localparam logic [31:0] IR_ADD  = 32'h191A_0000;
    localparam logic [31:0] IR_MUL  = 32'h81A0_0000;
    localparam logic [31:0] IR_DIV  = 32'h7800_0000;
    localparam logic [31:0] IR_NEG  = 32'h8800_0000;
    localparam logic [31:0] IR_NOP  = 32'hD000_0000;
    localparam logic [31:0] IR_UNK  = 32'h6000_0000;
    localparam logic [31:0] IR_HALT = 32'hD800_0000;

    typedef struct {
        logic        mr;
        logic [31:0] irv;
        logic [17:0] ctrl;
        logic [4:0]  alu;
        logic        rn;
        logic        flt;
    } rec_t;

    rec_t  q[$];
    rec_t  cur;
    int    cur_idx = 0;
    bit    chk_en  = 1'b0;
    int    n_cmp   = 0;
    int    n_bad   = 0;
    int    ncyc;

    logic [17:0] dut_ctrl;
    assign dut_ctrl = {Rout, Rin, Grc, Grb, Gra, LOin, HIin, Zhighout, Zlowout,
                       Zin, Yin, IRin, MDRout, MDRin, memRead, IncPC, MARin, PCout};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic push(input logic mr, input logic [31:0] irv, input logic [17:0] c,
                        input logic [4:0] a, input logic rn, input logic f);
        rec_t r;
        r.mr = mr; r.irv = irv; r.ctrl = c; r.alu = a; r.rn = rn; r.flt = f;
        q.push_back(r);
    endtask

    // One instruction: fetch with `waits` not-ready T1 cycles, then its execute steps
    task automatic model_instr(input logic [31:0] irv, input int waits, output int n);
        int start;
        logic [4:0] op;
        start = q.size();
        op = irv[31:27];
        push(1'b1, irv, C_PCOUT | C_MARIN | C_INCPC, 5'd0, 1'b1, 1'b0);
        for (int w = 0; w < waits; w++)
            push(1'b0, irv, C_MEMRD | C_MDRIN, 5'd0, 1'b1, 1'b0);
        push(1'b1, irv, C_MEMRD | C_MDRIN, 5'd0, 1'b1, 1'b0);
        push(1'b1, irv, C_MDROUT | C_IRIN, 5'd0, 1'b1, 1'b0);
        if (op >= 5'd3 && op <= 5'd11) begin
            push(1'b1, irv, C_GRB | C_ROUT | C_YIN, 5'd0, 1'b1, 1'b0);
            push(1'b1, irv, C_GRC | C_ROUT | C_ZIN, op, 1'b1, 1'b0);
            push(1'b1, irv, C_ZLOW | C_GRA | C_RIN, 5'd0, 1'b1, 1'b0);
        end else if (op == 5'd15 || op == 5'd16) begin
            push(1'b1, irv, C_GRA | C_ROUT | C_YIN, 5'd0, 1'b1, 1'b0);
            push(1'b1, irv, C_GRB | C_ROUT | C_ZIN, op, 1'b1, 1'b0);
            push(1'b1, irv, C_ZLOW | C_LOIN, 5'd0, 1'b1, 1'b0);
            push(1'b1, irv, C_ZHIGH | C_HIIN, 5'd0, 1'b1, 1'b0);
        end else if (op == 5'd17 || op == 5'd18) begin
            push(1'b1, irv, C_GRB | C_ROUT | C_ZIN, op, 1'b1, 1'b0);
            push(1'b1, irv, C_ZLOW | C_GRA | C_RIN, 5'd0, 1'b1, 1'b0);
        end else begin
            push(1'b1, irv, 18'd0, 5'd0, 1'b1, 1'b0);
        end
        n = q.size() - start;
    endtask

    task automatic push_halted(input int cycles, input logic [31:0] irv, input logic mr,
                               input logic f);
        for (int i = 0; i < cycles; i++)
            push(mr, irv, 18'd0, 5'd0, 1'b0, f);
    endtask

    task automatic run_queue(input int from, input int upto);
        for (int i = from; i < upto; i++) begin
            @(negedge clock);
            mem_ready = q[i].mr;
            ir        = q[i].irv;
            cur       = q[i];
            cur_idx   = i;
            chk_en    = 1'b1;
            #3;
            chk_en    = 1'b0;
        end
    endtask

    task automatic do_reset();
        chk_en    = 1'b0;
        clear_n   = 1'b0;
        mem_ready = 1'b0;
        ir        = 32'd0;
        repeat (3) @(negedge clock);
        #1;
        check("rst_ctrl", 32'(dut_ctrl), 32'd0);
        check("rst_alu_op", 32'(alu_op), 32'd0);
        check("rst_run", 32'(run), 32'd1);
        check("rst_mem_fault", 32'(mem_fault), 32'd0);
        @(posedge clock);
        #1 clear_n = 1'b1;
        @(negedge clock);
    endtask

    // Per-cycle compare against the expected record
    initial begin
        forever begin
            @(negedge clock);
            #2;
            if (chk_en) begin
                check($sformatf("ctrl[%0d]", cur_idx), 32'(dut_ctrl), 32'(cur.ctrl));
                check($sformatf("alu_op[%0d]", cur_idx), 32'(alu_op), 32'(cur.alu));
                check($sformatf("run[%0d]", cur_idx), 32'(run), 32'(cur.rn));
                check($sformatf("mem_fault[%0d]", cur_idx), 32'(mem_fault), 32'(cur.flt));
                check($sformatf("gr_select[%0d]", cur_idx),
                      32'($countones({Gra, Grb, Grc}) <= 1), 32'd1);
                check($sformatf("rin_rout[%0d]", cur_idx), 32'(Rin & Rout), 32'd0);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, n_cmp=%0d", n_cmp);
        $fatal(1, "watchdog");
    end

    initial begin
        clear_n   = 1'b0;
        mem_ready = 1'b0;
        ir        = 32'd0;

        // Normal instruction stream ending in halt
        do_reset();
        q.delete();
        model_instr(IR_NOT, 0, ncyc);  check("len_not", ncyc, 5);
        model_instr(IR_ADD, 0, ncyc);  check("len_add", ncyc, 6);
        model_instr(IR_MUL, 0, ncyc);  check("len_mul", ncyc, 7);
        model_instr(IR_DIV, 0, ncyc);  check("len_div", ncyc, 7);
        model_instr(IR_NEG, 0, ncyc);  check("len_neg", ncyc, 5);
        model_instr(IR_ADD, 3, ncyc);  check("len_add_wait3", ncyc, 9);
        model_instr(IR_ADD, 14, ncyc); check("len_add_wait14", ncyc, 20);
        model_instr(IR_NOP, 0, ncyc);  check("len_nop", ncyc, 4);
        model_instr(IR_UNK, 0, ncyc);  check("len_unknown", ncyc, 4);
        model_instr(IR_HALT, 0, ncyc); check("len_halt_fetch", ncyc, 4);
        check("add_t4_ctrl", 32'(q[5 + 4].ctrl), 32'h0_8100 | 32'h2_0000);
        check("add_t4_alu", 32'(q[5 + 4].alu), 32'd3);
        push_halted(20, IR_HALT, 1'b1, 1'b0);
        run_queue(0, q.size());

        // Memory never ready: fault after 15 T1 cycles
        do_reset();
        q.delete();
        push(1'b0, IR_ADD, C_PCOUT | C_MARIN | C_INCPC, 5'd0, 1'b1, 1'b0);
        for (int i = 0; i < 15; i++)
            push(1'b0, IR_ADD, C_MEMRD | C_MDRIN, 5'd0, 1'b1, 1'b0);
        push_halted(6, IR_ADD, 1'b1, 1'b1);
        run_queue(0, q.size());

        // Reset asserted during ADD T4
        do_reset();
        q.delete();
        model_instr(IR_ADD, 0, ncyc);
        run_queue(0, 4);
        @(negedge clock);
        mem_ready = q[4].mr;
        ir        = q[4].irv;
        cur       = q[4];
        cur_idx   = 4;
        chk_en    = 1'b1;
        #3;
        chk_en    = 1'b0;
        clear_n   = 1'b0;
        #1;
        check("abort_zin", 32'(Zin), 32'd0);
        check("abort_ctrl", 32'(dut_ctrl), 32'd0);
        check("abort_alu_op", 32'(alu_op), 32'd0);
        check("abort_run", 32'(run), 32'd1);
        check("abort_mem_fault", 32'(mem_fault), 32'd0);

        // Restart from T0 after the abort
        do_reset();
        q.delete();
        model_instr(IR_ADD, 0, ncyc);
        model_instr(IR_MUL, 1, ncyc);
        run_queue(0, q.size());

        @(negedge clock);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
